// File: rtl/reg_file_pkg.sv
// Shared defaults and dump-stream FSM state type for the multi-ported register file.
package reg_file_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef enum logic [1:0] {
    DUMP_IDLE   = 2'd0,
    DUMP_STREAM = 2'd1,
    DUMP_DONE   = 2'd2
  } dump_state_t;

endpackage

// File: rtl/reg_file_sb.sv
// Register scoreboard: one busy bit per register, set on issue, cleared by any enabled write.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NWR   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_rd,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] wa,
  output logic [NREGS-1:0]  busy
);

  logic [NREGS-1:0] busy_nxt;

  // Clears are applied first so that a same-cycle issue to the same register wins.
  always_comb begin
    busy_nxt = busy;
    for (int i = 0; i < NWR; i++) begin
      if (we[i]) busy_nxt[wa[i*AW +: AW]] = 1'b0;
    end
    if (iss_en && (iss_rd != '0)) busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with scoreboard and a valid/ready register dump stream.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = 2,
  parameter  int NWR   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NRD*AW-1:0]  ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]     rbusy,
  input  logic [NWR*AW-1:0]  wa,
  input  logic [NWR-1:0]     we,
  input  logic [NWR*XLEN-1:0] wd,
  input  logic               iss_en,
  input  logic [AW-1:0]      iss_rd,
  input  logic               dump_req,
  output logic               dump_valid,
  input  logic               dump_ready,
  output logic [AW-1:0]      dump_idx,
  output logic [XLEN-1:0]    dump_data,
  output logic               dump_busy,
  output logic               dump_done
);

  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [AW-1:0]    raddr [NRD+1];
  logic [XLEN-1:0]  rval  [NRD+1];
  dump_state_t      state, state_nxt;
  logic [AW-1:0]    idx_nxt;

  // Later ports overwrite earlier ones, so the highest-index port wins a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREGS; k++) regs[k] <= '0;
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (we[i] && (wa[i*AW +: AW] != '0)) regs[wa[i*AW +: AW]] <= wd[i*XLEN +: XLEN];
      end
    end
  end

  // The dump stream shares the read path as an extra read port.
  always_comb begin
    for (int p = 0; p < NRD; p++) raddr[p] = ra[p*AW +: AW];
    raddr[NRD] = dump_idx;
  end

  always_comb begin
    for (int p = 0; p <= NRD; p++) begin
      rval[p] = (raddr[p] == '0) ? '0 : regs[raddr[p]];
`ifdef REG_FILE_BYPASS_EN
      for (int i = 0; i < NWR; i++) begin
        if (we[i] && (wa[i*AW +: AW] == raddr[p]) && (raddr[p] != '0))
          rval[p] = wd[i*XLEN +: XLEN];
      end
`endif
    end
  end

  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      rd[p*XLEN +: XLEN] = rval[p];
      rbusy[p]           = (raddr[p] == '0) ? 1'b0 : busy[raddr[p]];
    end
  end

  reg_file_sb #(.NREGS(NREGS), .NWR(NWR), .AW(AW)) u_sb (
    .clk    (clk),
    .rst_n  (rst_n),
    .iss_en (iss_en),
    .iss_rd (iss_rd),
    .we     (we),
    .wa     (wa),
    .busy   (busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= DUMP_IDLE;
      dump_idx <= '0;
    end else begin
      state    <= state_nxt;
      dump_idx <= idx_nxt;
    end
  end

  // The index wraps back to 0 after the last beat, leaving it ready for the next dump.
  always_comb begin
    state_nxt = state;
    idx_nxt   = dump_idx;
    case (state)
      DUMP_IDLE: begin
        if (dump_req) begin
          state_nxt = DUMP_STREAM;
          idx_nxt   = '0;
        end
      end
      DUMP_STREAM: begin
        if (dump_ready) begin
          idx_nxt = dump_idx + AW'(1);
          if (dump_idx == AW'(NREGS - 1)) state_nxt = DUMP_DONE;
        end
      end
      DUMP_DONE: state_nxt = DUMP_IDLE;
      default:   state_nxt = DUMP_IDLE;
    endcase
  end

  assign dump_valid = (state == DUMP_STREAM);
  assign dump_busy  = (state != DUMP_IDLE);
  assign dump_done  = (state == DUMP_DONE);
  assign dump_data  = rval[NRD];

endmodule
